// File: rtl/core_link_fifo.sv
// Show-ahead FIFO on the horizontal activation link between neighbouring cores.
// Adds occupancy and almost-full reporting, a synchronous flush and a sticky overflow flag.
module core_link_fifo #(
    parameter int unsigned CACHE_DATA_WIDTH = 128,
    parameter int unsigned DEPTH            = 4,
    parameter int unsigned AFULL_THRESH     = 3,
    parameter int unsigned CNT_WIDTH        = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        flush,
    input  logic                        err_clr,
    input  logic [CACHE_DATA_WIDTH-1:0] hlink_wdata,
    input  logic                        hlink_wen,
    output logic                        hlink_wready,
    output logic [CACHE_DATA_WIDTH-1:0] hlink_rdata,
    output logic                        hlink_rvalid,
    input  logic                        hlink_rready,
    output logic [CNT_WIDTH-1:0]        fifo_count,
    output logic                        almost_full,
    output logic                        overflow_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CACHE_DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]            wr_ptr, rd_ptr;
    logic [PTR_W-1:0]            wr_ptr_nxt, rd_ptr_nxt;
    logic [CNT_WIDTH-1:0]        count_nxt;
    logic [CACHE_DATA_WIDTH-1:0] rdata_nxt;
    logic                        push, pop, ovf;

    assign push = hlink_wen && hlink_wready;
    assign pop  = hlink_rvalid && hlink_rready;
    assign ovf  = hlink_wen && !hlink_wready;

    // Next pointers/count; the head word is precomputed so hlink_rdata is a flop.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = fifo_count;
        rdata_nxt  = hlink_rdata;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_nxt = fifo_count + CNT_WIDTH'(1);
                2'b01:   count_nxt = fifo_count - CNT_WIDTH'(1);
                default: count_nxt = fifo_count;
            endcase
            // Empty after this edge: hold the last head word.
            if (count_nxt != '0) begin
                if (push && (wr_ptr == rd_ptr_nxt)) rdata_nxt = hlink_wdata;
                else                                 rdata_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            hlink_rdata  <= '0;
            hlink_rvalid <= 1'b0;
            hlink_wready <= 1'b1;
            almost_full  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            fifo_count   <= count_nxt;
            hlink_rdata  <= rdata_nxt;
            hlink_rvalid <= (count_nxt != '0);
            hlink_wready <= (count_nxt != CNT_WIDTH'(DEPTH));
            almost_full  <= (count_nxt >= CNT_WIDTH'(AFULL_THRESH));
            if (ovf)          overflow_err <= 1'b1;
            else if (err_clr) overflow_err <= 1'b0;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (rstn && !flush && push) mem[wr_ptr] <= hlink_wdata;
    end

endmodule
